// File: rtl/stack_seq4.sv
// Per-thread command holding registers for the four-thread barrel data stack.
// Each command is issued in its thread's slot; the pre-operation head is returned one cycle later.
module stack_seq4 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_thread,
  input  logic             cmd_we,
  input  logic [1:0]       cmd_delta,
  input  logic [WIDTH-1:0] cmd_wd,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic [WIDTH-1:0] stk_rd,
  output logic [1:0]       slot,
  output logic             rsp_valid,
  output logic [1:0]       rsp_thread,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             err_clear,
  output logic [3:0]       err_over,
  output logic [3:0]       err_under
);

  localparam int unsigned DW = $clog2(DEPTH + 2);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH + 1);

  logic [1:0]       slot_q, slot_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       we_q, we_d;
  logic [1:0]       delta_q [4];
  logic [1:0]       delta_d [4];
  logic [WIDTH-1:0] wd_q [4];
  logic [WIDTH-1:0] wd_d [4];
  logic [DW-1:0]    depth_q [4];
  logic [DW-1:0]    depth_d [4];
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_thread_q, rsp_thread_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       err_over_q, err_over_d;
  logic [3:0]       err_under_q, err_under_d;
  logic             issue;

  assign issue = pend_q[slot_q];

  always_comb begin
    slot_d       = slot_q + 2'd1;
    pend_d       = pend_q;
    we_d         = we_q;
    delta_d      = delta_q;
    wd_d         = wd_q;
    depth_d      = depth_q;
    rsp_valid_d  = issue;
    rsp_thread_d = rsp_thread_q;
    rsp_data_d   = rsp_data_q;
    err_over_d   = err_clear ? '0 : err_over_q;
    err_under_d  = err_clear ? '0 : err_under_q;
    stk_we       = 1'b0;
    stk_delta    = '0;
    stk_wd       = '0;
    cmd_ready    = !pend_q[cmd_thread];

    if (issue) begin
      stk_we         = we_q[slot_q];
      stk_delta      = delta_q[slot_q];
      stk_wd         = wd_q[slot_q];
      pend_d[slot_q] = 1'b0;
      rsp_thread_d   = slot_q;
      rsp_data_d     = stk_rd;
      // Error set is applied after the clear so a same-cycle error leaves its flag set.
      if (delta_q[slot_q] == 2'b01) begin
        if (depth_q[slot_q] == DMAX) err_over_d[slot_q] = 1'b1;
        else depth_d[slot_q] = depth_q[slot_q] + DW'(1);
      end else if (delta_q[slot_q] == 2'b11) begin
        if (depth_q[slot_q] == '0) err_under_d[slot_q] = 1'b1;
        else depth_d[slot_q] = depth_q[slot_q] - DW'(1);
      end
    end

    if (cmd_valid && cmd_ready) begin
      pend_d[cmd_thread]  = 1'b1;
      we_d[cmd_thread]    = cmd_we;
      delta_d[cmd_thread] = cmd_delta;
      wd_d[cmd_thread]    = cmd_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      pend_q       <= '0;
      we_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_thread_q <= '0;
      rsp_data_q   <= '0;
      err_over_q   <= '0;
      err_under_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        delta_q[i] <= '0;
        wd_q[i]    <= '0;
        depth_q[i] <= '0;
      end
    end else begin
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      we_q         <= we_d;
      delta_q      <= delta_d;
      wd_q         <= wd_d;
      depth_q      <= depth_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_thread_q <= rsp_thread_d;
      rsp_data_q   <= rsp_data_d;
      err_over_q   <= err_over_d;
      err_under_q  <= err_under_d;
    end
  end

  assign slot       = slot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_thread = rsp_thread_q;
  assign rsp_data   = rsp_data_q;
  assign err_over   = err_over_q;
  assign err_under  = err_under_q;

endmodule

// File: tb/tb_stack_seq4.sv
// Scoreboard bench for stack_seq4 with a behavioural four-thread barrel stack on the stk_* port.
module tb_stack_seq4;

  localparam int W = 16;
  localparam int D = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_we;
  logic [1:0]   cmd_thread, cmd_delta;
  logic [W-1:0] cmd_wd;
  logic         stk_we;
  logic [1:0]   stk_delta;
  logic [W-1:0] stk_wd, stk_rd;
  logic [1:0]   slot;
  logic         rsp_valid;
  logic [1:0]   rsp_thread;
  logic [W-1:0] rsp_data;
  logic         err_clear;
  logic [3:0]   err_over, err_under;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]   thr;
    logic [W-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  stack_seq4 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_thread(cmd_thread),
    .cmd_we(cmd_we), .cmd_delta(cmd_delta), .cmd_wd(cmd_wd),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
    .slot(slot),
    .rsp_valid(rsp_valid), .rsp_thread(rsp_thread), .rsp_data(rsp_data),
    .err_clear(err_clear), .err_over(err_over), .err_under(err_under)
  );

  always #5 clk = ~clk;

  // Barrel stack fixture: rotates on its own slot counter, head read before the operation.
  logic [1:0]   m_slot;
  logic [W-1:0] m_head [4];
  logic [W-1:0] m_tail [4][32];
  int           m_sp   [4];

  assign stk_rd = m_head[m_slot];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_slot <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        m_head[i] <= 16'(16'h1100 * (i + 1));
        m_sp[i]   <= 0;
      end
    end else begin
      m_slot <= m_slot + 2'd1;
      if (stk_delta == 2'b01) begin
        if (m_sp[m_slot] < 32) begin
          m_tail[m_slot][m_sp[m_slot]] <= m_head[m_slot];
          m_sp[m_slot] <= m_sp[m_slot] + 1;
        end
        if (stk_we) m_head[m_slot] <= stk_wd;
      end else if (stk_delta == 2'b11) begin
        if (m_sp[m_slot] > 0) begin
          m_head[m_slot] <= stk_we ? stk_wd : m_tail[m_slot][m_sp[m_slot] - 1];
          m_sp[m_slot]   <= m_sp[m_slot] - 1;
        end else begin
          m_head[m_slot] <= stk_we ? stk_wd : 16'hDEAD;
        end
      end else if (stk_we) begin
        m_head[m_slot] <= stk_wd;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got thread %0d data %0h expected none at %0t",
                 rsp_thread, rsp_data, $time);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_thread", 32'(rsp_thread), 32'(e.thr));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int t, input logic we, input logic [1:0] d, input logic [W-1:0] wd,
                      input logic [W-1:0] exp, input int align, input bit exp_rsp);
    rsp_t e;
    if (align >= 0)
      for (int n = 0; n < 8 && int'(m_slot) != align; n++) @(negedge clk);
    cmd_thread = t[1:0];
    cmd_we     = we;
    cmd_delta  = d;
    cmd_wd     = wd;
    cmd_valid  = 1'b1;
    #1;
    for (int n = 0; n < 20 && !cmd_ready; n++) begin
      @(negedge clk);
      #1;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    if (exp_rsp) begin
      e.thr  = t[1:0];
      e.data = exp;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("idle_slot", 32'(slot), 32'(i % 4));
      chk("idle_we", 32'(stk_we), 32'd0);
      chk("idle_delta", 32'(stk_delta), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_thread = '0; cmd_we = 1'b0;
    cmd_delta = '0; cmd_wd = '0; err_clear = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_thread", 32'(rsp_thread), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err_over", 32'(err_over), 32'd0);
    chk("rst_err_under", 32'(err_under), 32'd0);
    chk("rst_stk_we", 32'(stk_we), 32'd0);
    chk("rst_stk_delta", 32'(stk_delta), 32'd0);
    chk("rst_stk_wd", 32'(stk_wd), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    idle_check(8);

    // Thread 2 push then pop.
    send(2, 1'b1, 2'b01, 16'h1234, 16'h3300, -1, 1'b1);
    send(2, 1'b0, 2'b11, 16'h0000, 16'h1234, -1, 1'b1);
    drain();
    chk("t2_over", 32'(err_over), 32'd0);
    chk("t2_under", 32'(err_under), 32'd0);

    // All four threads pending by the slot-3 cycle; head overwrite without move.
    for (int t = 0; t < 4; t++)
      send(t, 1'b1, 2'b10, 16'(16'h5000 + t), 16'(16'h1100 * (t + 1)), t, 1'b1);
    drain();

    // Back-to-back commands to thread 1: second one waits for the issue edge.
    send(1, 1'b1, 2'b10, 16'h5111, 16'h5001, 2, 1'b1);
    cmd_thread = 2'd1; cmd_we = 1'b0; cmd_delta = 2'b00; cmd_wd = '0; cmd_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("busy_ready", 32'(cmd_ready), 32'd0);
      if (k < 2) chk("busy_nop_we", 32'(stk_we), 32'd0);
      else begin
        chk("issue_we", 32'(stk_we), 32'd1);
        chk("issue_delta", 32'(stk_delta), 32'd2);
        chk("issue_wd", 32'(stk_wd), 32'h5111);
      end
      @(negedge clk);
      #1;
    end
    chk("ready_after_issue", 32'(cmd_ready), 32'd1);
    begin
      rsp_t e;
      e.thr = 2'd1;
      e.data = 16'h5111;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // Overflow on thread 0.
    for (int i = 0; i < D + 1; i++)
      send(0, 1'b1, 2'b01, 16'(16'h0100 + i), (i == 0) ? 16'h5000 : 16'(16'h0100 + i - 1), -1, 1'b1);
    drain();
    chk("pre_over", 32'(err_over), 32'd0);
    send(0, 1'b1, 2'b01, 16'(16'h0100 + D + 1), 16'(16'h0100 + D), -1, 1'b1);
    drain();
    chk("over_set", 32'(err_over), 32'b0001);
    chk("over_under", 32'(err_under), 32'd0);

    // Underflow on empty thread 3.
    send(3, 1'b0, 2'b11, 16'h0000, 16'h5003, -1, 1'b1);
    drain();
    chk("under_set", 32'(err_under), 32'b1000);

    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("clr_over", 32'(err_over), 32'd0);
    chk("clr_under", 32'(err_under), 32'd0);

    // Clear coincident with a new underflow at the issue edge.
    send(3, 1'b0, 2'b11, 16'h0000, 16'hDEAD, 2, 1'b1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    drain();
    chk("clr_vs_under", 32'(err_under), 32'b1000);
    chk("clr_vs_over", 32'(err_over), 32'd0);

    // Depth held at DEPTH+1: exactly DEPTH+1 pops before thread 0 underflows.
    for (int j = 0; j < D + 1; j++)
      send(0, 1'b0, 2'b11, 16'h0000, 16'(16'h0113 - j), -1, 1'b1);
    drain();
    chk("held_no_under", 32'(err_under), 32'b1000);
    send(0, 1'b0, 2'b11, 16'h0000, 16'h0100, -1, 1'b1);
    drain();
    chk("held_under", 32'(err_under), 32'b1001);

    // Reset with threads 1 and 2 pending.
    send(1, 1'b1, 2'b01, 16'h7777, 16'h0000, 1, 1'b0);
    send(2, 1'b1, 2'b01, 16'h8888, 16'h0000, 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_thread = 2'd1;
    #1;
    chk("rst2_ready1", 32'(cmd_ready), 32'd1);
    cmd_thread = 2'd2;
    #1;
    chk("rst2_ready2", 32'(cmd_ready), 32'd1);
    chk("rst2_flags", 32'({err_over, err_under}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(8);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
